// File: rtl/tmr0_ctrl_if.sv
// rtl/tmr0_ctrl_if.sv - CPU-side bus between the core and the TMR0/WDT sequencer
//
// Signals (named from the sequencer's point of view):
//   tmr0_wr, option_wr, wr_data  CPU write strobes and write data
//   t0if_clr, t0ie               T0IF clear strobe and TMR0 interrupt enable
//   sleep_req, clrwdt_req        SLEEP / CLRWDT instruction pulses
//   option_out, t0if, t0_irq     OPTION readback, overflow flag, interrupt
//   cpu_stall                    core must hold its current instruction
// Modports: master = CPU core, slave = tmr0_ctrl.

interface tmr0_ctrl_if;
    logic       tmr0_wr;
    logic       option_wr;
    logic [7:0] wr_data;
    logic       t0if_clr;
    logic       t0ie;
    logic       sleep_req;
    logic       clrwdt_req;
    logic [7:0] option_out;
    logic       t0if;
    logic       t0_irq;
    logic       cpu_stall;

    modport master (
        output tmr0_wr, option_wr, wr_data, t0if_clr, t0ie, sleep_req, clrwdt_req,
        input  option_out, t0if, t0_irq, cpu_stall
    );

    modport slave (
        input  tmr0_wr, option_wr, wr_data, t0if_clr, t0ie, sleep_req, clrwdt_req,
        output option_out, t0if, t0_irq, cpu_stall
    );
endinterface

// File: rtl/tmr0_ctrl.sv
// rtl/tmr0_ctrl.sv - TMR0/WDT sequencer: OPTION, T0IF, TMR0 writes, PSA swap, SLEEP/WDT states
//
// Optional feature macro: TMR0_SLEEP_WAKE_EN (TMR0 overflow wakes the core from SLEEP).
//
// Ports:
//   clkout, rst         instruction clock, synchronous active-high reset
//   cpu                 tmr0_ctrl_if.slave CPU bus (writes, T0IF, SLEEP/CLRWDT, stall)
//   t0cs/t0se/psa/ps    OPTION fields to the timer
//   tmr0_load(_val)     timer load strobe and data
//   tmr0_inhibit        timer must not increment
//   presc_clr, wdt_clr  clear shared prescaler / WDT counter
//   tmr0if_set_en       overflow pulse from the timer
//   wdt_timeout         WDT overflow pulse from the timer
//   sleeping            core clock gated
//   wdt_rst_req         device reset request after a WDT timeout in RUN
//   to_n, pd_n          STATUS TO#/PD#, power-on initialised, untouched by rst

module tmr0_ctrl #(
    parameter logic [7:0] OPTION_RST     = 8'hFF,
    parameter int         INHIBIT_CYCLES = 2
) (
    input  logic       clkout,
    input  logic       rst,
    tmr0_ctrl_if.slave cpu,
    output logic       t0cs,
    output logic       t0se,
    output logic       psa,
    output logic [2:0] ps,
    output logic       tmr0_load,
    output logic [7:0] tmr0_load_val,
    output logic       tmr0_inhibit,
    output logic       presc_clr,
    output logic       wdt_clr,
    input  logic       tmr0if_set_en,
    input  logic       wdt_timeout,
    output logic       sleeping,
    output logic       wdt_rst_req,
    output logic       to_n,
    output logic       pd_n
);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_PSW1,
        ST_PSW2,
        ST_SLP,
        ST_WAKE,
        ST_WRST
    } state_t;

    localparam logic [1:0] INH_LOAD = 2'(INHIBIT_CYCLES);

    state_t     state_q, state_d;
    logic [7:0] option_q, option_d;
    logic [7:0] pend_q, pend_d;      // OPTION value parked during the PSA swap
    logic [1:0] inh_q, inh_d;
    logic       t0if_q, t0if_d;

    // Power-on values only: a WDT-induced rst must leave TO#/PD# intact so
    // firmware can tell why it restarted.
    logic       to_n_q = 1'b1;
    logic       pd_n_q = 1'b1;
    logic       to_n_d, pd_n_d;

    assign t0cs = option_q[5];
    assign t0se = option_q[4];
    assign psa  = option_q[3];
    assign ps   = option_q[2:0];

    assign tmr0_load_val  = cpu.wr_data;
    assign cpu.option_out = option_q;
    assign cpu.t0if       = t0if_q;
    assign cpu.t0_irq     = t0if_q & cpu.t0ie;

    // In SLEEP the internal-clock timer stops with the core clock.
    assign tmr0_inhibit = (inh_q != 2'd0) || (state_q == ST_SLP && !t0cs);
    assign sleeping     = (state_q == ST_SLP) || (state_q == ST_WAKE);
    assign wdt_rst_req  = (state_q == ST_WRST);
    assign to_n         = to_n_q;
    assign pd_n         = pd_n_q;

    // Set wins over clear so an overflow coinciding with the clear is not lost.
    always_comb begin
        t0if_d = t0if_q;
        if (tmr0if_set_en)
            t0if_d = 1'b1;
        else if (cpu.t0if_clr)
            t0if_d = 1'b0;
    end

    always_comb begin
        state_d       = state_q;
        option_d      = option_q;
        pend_d        = pend_q;
        inh_d         = (inh_q != 2'd0) ? inh_q - 2'd1 : 2'd0;
        to_n_d        = to_n_q;
        pd_n_d        = pd_n_q;
        tmr0_load     = 1'b0;
        presc_clr     = 1'b0;
        wdt_clr       = 1'b0;
        cpu.cpu_stall = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (wdt_timeout) begin
                    state_d = ST_WRST;
                    to_n_d  = 1'b0;
                    pd_n_d  = 1'b1;
                end else if (cpu.sleep_req) begin
                    wdt_clr   = 1'b1;
                    presc_clr = psa;
                    to_n_d    = 1'b1;
                    pd_n_d    = 1'b0;
                    state_d   = ST_SLP;
                end else if (cpu.clrwdt_req) begin
                    wdt_clr   = 1'b1;
                    presc_clr = psa;
                    to_n_d    = 1'b1;
                    pd_n_d    = 1'b1;
                end else if (cpu.tmr0_wr) begin
                    // A simultaneous OPTION write falls through and is dropped.
                    tmr0_load = 1'b1;
                    presc_clr = !psa;
                    inh_d     = INH_LOAD;
                end else if (cpu.option_wr) begin
                    if (cpu.wr_data[3] != psa) begin
                        // Prescaler changes owner: clear it with the old
                        // assignment still in place before switching.
                        cpu.cpu_stall = 1'b1;
                        pend_d        = cpu.wr_data;
                        state_d       = ST_PSW1;
                    end else begin
                        option_d = cpu.wr_data;
                    end
                end
            end
            ST_PSW1: begin
                presc_clr     = 1'b1;
                wdt_clr       = 1'b1;
                cpu.cpu_stall = 1'b1;
                state_d       = ST_PSW2;
            end
            ST_PSW2: begin
                presc_clr = 1'b1;
                option_d  = pend_q;
                state_d   = ST_RUN;
            end
            ST_SLP: begin
                if (wdt_timeout) begin
                    to_n_d  = 1'b0;
                    state_d = ST_WAKE;
                end
`ifdef TMR0_SLEEP_WAKE_EN
                else if (t0cs && tmr0if_set_en && cpu.t0ie) begin
                    state_d = ST_WAKE;
                end
`endif
            end
            ST_WAKE: begin
                state_d = ST_RUN;
            end
            ST_WRST: begin
                state_d = ST_WRST;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clkout) begin
        if (rst) begin
            state_q  <= ST_RUN;
            option_q <= OPTION_RST;
            pend_q   <= OPTION_RST;
            inh_q    <= 2'd0;
            t0if_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            option_q <= option_d;
            pend_q   <= pend_d;
            inh_q    <= inh_d;
            t0if_q   <= t0if_d;
        end
    end

    always_ff @(posedge clkout) begin
        if (!rst) begin
            to_n_q <= to_n_d;
            pd_n_q <= pd_n_d;
        end
    end

endmodule

// File: tb/tb_tmr0_ctrl.sv
// tb/tb_tmr0_ctrl.sv - self-checking bench for tmr0_ctrl

module tb_tmr0_ctrl;

    localparam int INH = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       t0cs, t0se, psa;
    logic [2:0] ps;
    logic       tmr0_load;
    logic [7:0] tmr0_load_val;
    logic       tmr0_inhibit, presc_clr, wdt_clr;
    logic       tmr0if_set_en = 1'b0;
    logic       wdt_timeout = 1'b0;
    logic       sleeping, wdt_rst_req, to_n, pd_n;

    int checks = 0;
    int errors = 0;

    tmr0_ctrl_if bus ();

    tmr0_ctrl #(.OPTION_RST(8'hFF), .INHIBIT_CYCLES(INH)) dut (
        .clkout        (clk),
        .rst           (rst),
        .cpu           (bus),
        .t0cs          (t0cs),
        .t0se          (t0se),
        .psa           (psa),
        .ps            (ps),
        .tmr0_load     (tmr0_load),
        .tmr0_load_val (tmr0_load_val),
        .tmr0_inhibit  (tmr0_inhibit),
        .presc_clr     (presc_clr),
        .wdt_clr       (wdt_clr),
        .tmr0if_set_en (tmr0if_set_en),
        .wdt_timeout   (wdt_timeout),
        .sleeping      (sleeping),
        .wdt_rst_req   (wdt_rst_req),
        .to_n          (to_n),
        .pd_n          (pd_n)
    );

    always #5 clk = ~clk;

    // Inputs change at the falling edge; outputs are sampled 1ns later.
    task automatic next_cycle();
        @(negedge clk);
        bus.tmr0_wr    = 1'b0;
        bus.option_wr  = 1'b0;
        bus.t0if_clr   = 1'b0;
        bus.sleep_req  = 1'b0;
        bus.clrwdt_req = 1'b0;
        tmr0if_set_en  = 1'b0;
        wdt_timeout    = 1'b0;
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.wr_data = 8'h00;
        bus.t0ie    = 1'b0;
        do_reset();
        #1;
        if ({bus.option_out, bus.t0if, bus.cpu_stall, tmr0_load, presc_clr, wdt_clr, tmr0_inhibit}
            !== {8'hFF, 6'b0}) begin
            errors++;
            $display("FAIL reset_state: opt=%h t0if=%b stall=%b load=%b pclr=%b wclr=%b inh=%b, need opt=ff rest 0",
                     bus.option_out, bus.t0if, bus.cpu_stall, tmr0_load, presc_clr, wdt_clr, tmr0_inhibit);
        end
        checks++;
        if ({sleeping, wdt_rst_req, to_n, pd_n} !== 4'b0011) begin
            errors++;
            $display("FAIL reset_power: sleep/wrst/to_n/pd_n=%b%b%b%b need 0011", sleeping, wdt_rst_req, to_n, pd_n);
        end
        checks++;
    endtask

    task automatic test_option_write();
        do_reset();
        next_cycle();
        bus.option_wr = 1'b1;
        bus.wr_data   = 8'h07;
        #1;
        if ({bus.cpu_stall, wdt_clr, presc_clr, bus.option_out} !== {3'b100, 8'hFF}) begin
            errors++;
            $display("FAIL opt_wr_cycle: stall/wclr/pclr=%b%b%b opt=%h need 100 ff", bus.cpu_stall, wdt_clr, presc_clr, bus.option_out);
        end
        checks++;
        next_cycle();
        bus.tmr0_wr = 1'b1;     // stalled CPU: must be ignored
        #1;
        if ({bus.cpu_stall, wdt_clr, presc_clr, tmr0_load, bus.option_out} !== {4'b1110, 8'hFF}) begin
            errors++;
            $display("FAIL opt_psw1: stall/wclr/pclr/load=%b%b%b%b opt=%h need 1110 ff",
                     bus.cpu_stall, wdt_clr, presc_clr, tmr0_load, bus.option_out);
        end
        checks++;
        next_cycle();
        #1;
        if ({bus.cpu_stall, wdt_clr, presc_clr, bus.option_out} !== {3'b001, 8'hFF}) begin
            errors++;
            $display("FAIL opt_psw2: stall/wclr/pclr=%b%b%b opt=%h need 001 ff", bus.cpu_stall, wdt_clr, presc_clr, bus.option_out);
        end
        checks++;
        next_cycle();
        #1;
        if ({bus.option_out, t0cs, t0se, psa, ps, presc_clr} !== {8'h07, 6'b000111, 1'b0}) begin
            errors++;
            $display("FAIL opt_done: opt=%h fields=%b%b%b%b pclr=%b need 07 000111 0",
                     bus.option_out, t0cs, t0se, psa, ps, presc_clr);
        end
        checks++;
        // same PSA: immediate update without stall
        bus.option_wr = 1'b1;
        bus.wr_data   = 8'h25;
        #1;
        if (bus.cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL opt_same_psa_stall: stall=%b need 0", bus.cpu_stall);
        end
        checks++;
        next_cycle();
        #1;
        if (bus.option_out !== 8'h25) begin
            errors++;
            $display("FAIL opt_same_psa_val: opt=%h need 25", bus.option_out);
        end
        checks++;
    endtask

    task automatic test_tmr0_write();
        // OPTION is 8'h25 (psa=0) from the previous test
        next_cycle();
        bus.tmr0_wr   = 1'b1;
        bus.option_wr = 1'b1;   // simultaneous write: TMR0 wins
        bus.wr_data   = 8'h3C;
        #1;
        if ({tmr0_load, tmr0_load_val, presc_clr, tmr0_inhibit, bus.cpu_stall} !== {1'b1, 8'h3C, 3'b100}) begin
            errors++;
            $display("FAIL tmr0_wr: load=%b val=%h pclr=%b inh=%b stall=%b need 1 3c 1 0 0",
                     tmr0_load, tmr0_load_val, presc_clr, tmr0_inhibit, bus.cpu_stall);
        end
        checks++;
        for (int i = 0; i < INH + 1; i++) begin
            next_cycle();
            #1;
            if ({tmr0_load, tmr0_inhibit} !== {1'b0, (i < INH)}) begin
                errors++;
                $display("FAIL tmr0_inhibit_%0d: load=%b inh=%b need 0 %b", i, tmr0_load, tmr0_inhibit, (i < INH));
            end
            checks++;
        end
        if (bus.option_out !== 8'h25) begin
            errors++;
            $display("FAIL dual_write_opt: opt=%h need 25", bus.option_out);
        end
        checks++;
    endtask

    task automatic test_t0if();
        do_reset();
        bus.t0ie      = 1'b1;
        tmr0if_set_en = 1'b1;
        bus.t0if_clr  = 1'b1;
        next_cycle();
        #1;
        if ({bus.t0if, bus.t0_irq} !== 2'b11) begin
            errors++;
            $display("FAIL t0if_set_wins: t0if=%b irq=%b need 11", bus.t0if, bus.t0_irq);
        end
        checks++;
        bus.t0ie = 1'b0;
        #1;
        if (bus.t0_irq !== 1'b0) begin
            errors++;
            $display("FAIL t0_irq_masked: irq=%b need 0", bus.t0_irq);
        end
        checks++;
        bus.t0ie     = 1'b1;
        bus.t0if_clr = 1'b1;
        next_cycle();
        #1;
        if ({bus.t0if, bus.t0_irq} !== 2'b00) begin
            errors++;
            $display("FAIL t0if_clr: t0if=%b irq=%b need 00", bus.t0if, bus.t0_irq);
        end
        checks++;
    endtask

    task automatic test_sleep_wake();
        do_reset();
        next_cycle();
        bus.option_wr = 1'b1;
        bus.wr_data   = 8'hDF;  // t0cs=0, psa stays 1
        next_cycle();
        bus.sleep_req  = 1'b1;
        bus.clrwdt_req = 1'b1;  // sleep wins
        #1;
        if ({wdt_clr, presc_clr, sleeping} !== 3'b110) begin
            errors++;
            $display("FAIL sleep_cycle: wclr/pclr/sleep=%b%b%b need 110", wdt_clr, presc_clr, sleeping);
        end
        checks++;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            bus.tmr0_wr = 1'b1; // ignored while asleep
            #1;
            if ({sleeping, to_n, pd_n, tmr0_inhibit, tmr0_load} !== 5'b11010) begin
                errors++;
                $display("FAIL sleep_%0d: sleep/to_n/pd_n/inh/load=%b%b%b%b%b need 11010",
                         i, sleeping, to_n, pd_n, tmr0_inhibit, tmr0_load);
            end
            checks++;
        end
        next_cycle();
        wdt_timeout = 1'b1;
        next_cycle();
        #1;
        if ({sleeping, to_n, pd_n, wdt_rst_req} !== 4'b1000) begin
            errors++;
            $display("FAIL wake_state: sleep/to_n/pd_n/wrst=%b%b%b%b need 1000", sleeping, to_n, pd_n, wdt_rst_req);
        end
        checks++;
        next_cycle();
        bus.tmr0_wr = 1'b1;
        #1;
        if ({sleeping, tmr0_load, to_n, pd_n} !== 4'b0100) begin
            errors++;
            $display("FAIL wake_run: sleep/load/to_n/pd_n=%b%b%b%b need 0100", sleeping, tmr0_load, to_n, pd_n);
        end
        checks++;
    endtask

    task automatic test_wdt_reset();
        next_cycle();
        bus.clrwdt_req = 1'b1;
        #1;
        if ({wdt_clr, presc_clr} !== 2'b11) begin
            errors++;
            $display("FAIL clrwdt: wclr/pclr=%b%b need 11", wdt_clr, presc_clr);
        end
        checks++;
        next_cycle();
        #1;
        if ({to_n, pd_n} !== 2'b11) begin
            errors++;
            $display("FAIL clrwdt_status: to_n/pd_n=%b%b need 11", to_n, pd_n);
        end
        checks++;
        wdt_timeout    = 1'b1;
        bus.clrwdt_req = 1'b1;
        #1;
        if (wdt_clr !== 1'b0) begin
            errors++;
            $display("FAIL wdt_outranks_clrwdt: wclr=%b need 0", wdt_clr);
        end
        checks++;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            #1;
            if ({wdt_rst_req, to_n, pd_n} !== 3'b101) begin
                errors++;
                $display("FAIL wrst_%0d: wrst/to_n/pd_n=%b%b%b need 101", i, wdt_rst_req, to_n, pd_n);
            end
            checks++;
        end
        do_reset();
        bus.tmr0_wr = 1'b1;
        #1;
        if ({wdt_rst_req, to_n, pd_n, tmr0_load} !== 4'b0011) begin
            errors++;
            $display("FAIL wrst_after_rst: wrst/to_n/pd_n/load=%b%b%b%b need 0011", wdt_rst_req, to_n, pd_n, tmr0_load);
        end
        checks++;
    endtask

    task automatic test_sleep_t0_wake();
        logic exp_wake;
`ifdef TMR0_SLEEP_WAKE_EN
        exp_wake = 1'b1;
`else
        exp_wake = 1'b0;
`endif
        do_reset();             // OPTION=FF: t0cs=1
        bus.t0ie      = 1'b1;
        bus.sleep_req = 1'b1;
        next_cycle();
        next_cycle();
        tmr0if_set_en = 1'b1;
        next_cycle();
        #1;
        if ({sleeping, to_n, bus.t0if} !== 3'b111) begin
            errors++;
            $display("FAIL t0wake_cycle: sleep/to_n/t0if=%b%b%b need 111", sleeping, to_n, bus.t0if);
        end
        checks++;
        next_cycle();
        #1;
        if (sleeping !== !exp_wake) begin
            errors++;
            $display("FAIL t0wake_exit: sleep=%b need %b", sleeping, !exp_wake);
        end
        checks++;
        do_reset();
    endtask

    // Reference model: OPTION/T0IF/inhibit tracked as plain values and counters.
    task automatic test_random();
        logic [7:0] opt, pend;
        logic       t0if_m, run, load_e, swap_e, stall_e, pclr_e, wclr_e;
        int         psw_left, inh_left;
        do_reset();
        opt = 8'hFF; pend = 8'h00; t0if_m = 1'b0; psw_left = 0; inh_left = 0;
        for (int n = 0; n < 400; n++) begin
            next_cycle();
            bus.tmr0_wr   = ($urandom_range(0, 3) == 0);
            bus.option_wr = !bus.tmr0_wr && ($urandom_range(0, 3) == 0);
            bus.wr_data   = 8'($urandom);
            bus.t0ie      = 1'($urandom);
            bus.t0if_clr  = ($urandom_range(0, 3) == 0);
            tmr0if_set_en = ($urandom_range(0, 5) == 0);
            #1;
            run     = (psw_left == 0);
            load_e  = run && bus.tmr0_wr;
            swap_e  = run && bus.option_wr && (bus.wr_data[3] != opt[3]);
            stall_e = swap_e || (psw_left == 2);
            pclr_e  = (load_e && !opt[3]) || (psw_left > 0);
            wclr_e  = (psw_left == 2);
            if ({bus.cpu_stall, tmr0_load, presc_clr, wdt_clr, tmr0_inhibit, bus.option_out,
                 t0cs, t0se, psa, ps, bus.t0if, bus.t0_irq}
                !== {stall_e, load_e, pclr_e, wclr_e, (inh_left > 0), opt, opt[5:0], t0if_m, t0if_m & bus.t0ie}) begin
                errors++;
                $display("FAIL rand_%0d: stall/load/pclr/wclr/inh=%b%b%b%b%b opt=%h t0if/irq=%b%b need %b%b%b%b%b %h %b%b",
                         n, bus.cpu_stall, tmr0_load, presc_clr, wdt_clr, tmr0_inhibit, bus.option_out,
                         bus.t0if, bus.t0_irq, stall_e, load_e, pclr_e, wclr_e, (inh_left > 0), opt,
                         t0if_m, t0if_m & bus.t0ie);
            end
            checks++;
            if (load_e && tmr0_load_val !== bus.wr_data) begin
                errors++;
                $display("FAIL rand_val_%0d: val=%h need %h", n, tmr0_load_val, bus.wr_data);
            end
            if (load_e) checks++;
            inh_left = load_e ? INH : (inh_left > 0 ? inh_left - 1 : 0);
            if (psw_left == 1) opt = pend;
            if (psw_left > 0) psw_left--;
            if (run && !bus.tmr0_wr && bus.option_wr) begin
                if (swap_e) begin
                    pend = bus.wr_data;
                    psw_left = 2;
                end else begin
                    opt = bus.wr_data;
                end
            end
            if (tmr0if_set_en) t0if_m = 1'b1;
            else if (bus.t0if_clr) t0if_m = 1'b0;
        end
    endtask

    initial begin
        bus.tmr0_wr    = 1'b0;
        bus.option_wr  = 1'b0;
        bus.wr_data    = 8'h00;
        bus.t0if_clr   = 1'b0;
        bus.t0ie       = 1'b0;
        bus.sleep_req  = 1'b0;
        bus.clrwdt_req = 1'b0;
        test_reset();
        test_option_write();
        test_tmr0_write();
        test_t0if();
        test_sleep_wake();
        test_wdt_reset();
        test_sleep_t0_wake();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
